shift_sequencer: RTL and testbench

Multi-cycle controller for the 8-bit shift unit. It accepts one shift request at a time through a start/busy/done handshake and latches the operands. It then performs the shift as a sequence of bounded steps of at most MAX_STEP bit positions per cycle, so shift amounts up to 255 are handled. It sits between the CPU control unit and the shifter datapath.

---
 rtl/shift_sequencer_if.sv | 22 ++
 rtl/shift_sequencer.sv | 111 +++++++++++
 tb/tb_shift_sequencer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/shift_sequencer_if.sv
// Request/response bundle between the CPU control unit and the shift sequencer.
// The master drives the request; the slave (sequencer) returns status and result.
interface shift_sequencer_if;
   logic       start;
   logic [7:0] data1;
   logic [7:0] data2;
   logic [3:0] select;
   logic       busy;
   logic       done;
   logic [7:0] result;
   logic       error;

   modport master (
      output start, data1, data2, select,
      input  busy, done, result, error
   );

   modport slave (
      input  start, data1, data2, select,
      output busy, done, result, error
   );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle 8-bit shift controller: latches one request and applies the shift
// in steps of at most MaxStep positions per cycle, then pulses done.
module shift_sequencer #(
   parameter int unsigned MaxStep = 7
) (
   input logic                clk_i,
   input logic                rst_ni,
   shift_sequencer_if.slave   bus
);

   typedef enum logic {StIdle, StRun} state_e;

   localparam logic [3:0] StepMax = 4'(MaxStep);

   state_e     state_q, state_d;
   logic [7:0] acc_q, acc_d;
   logic [3:0] rem_q, rem_d;
   logic [3:0] op_q, op_d;
   logic [7:0] result_q, result_d;
   logic       done_q, done_d;
   logic       error_q, error_d;

   logic [3:0]  step;
   logic [3:0]  eff_amt;
   logic [7:0]  shifted;
   logic [15:0] rot;
   logic        op_ok;

   assign op_ok = (op_q[3:2] == 2'b01);
   assign step  = (rem_q < StepMax) ? rem_q : StepMax;
   assign rot   = {acc_q, acc_q} >> step;

   // Amounts beyond 8 saturate for shifts; rotates only care about the low 3 bits.
   always_comb begin
      eff_amt = 4'd0;
      case (bus.select)
         4'b0100, 4'b0101, 4'b0111: eff_amt = (bus.data2 > 8'd8) ? 4'd8 : bus.data2[3:0];
         4'b0110:                   eff_amt = {1'b0, bus.data2[2:0]};
         default:                   eff_amt = 4'd0;
      endcase
   end

   always_comb begin
      shifted = acc_q;
      case (op_q)
         4'b0100: shifted = acc_q >> step;
         4'b0101: shifted = acc_q << step;
         4'b0110: shifted = rot[7:0];
         4'b0111: shifted = $signed(acc_q) >>> step;
         default: shifted = acc_q;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      rem_d    = rem_q;
      op_d     = op_q;
      result_d = result_q;
      done_d   = 1'b0;
      error_d  = error_q;
      case (state_q)
         StIdle: begin
            if (bus.start) begin
               acc_d   = bus.data1;
               op_d    = bus.select;
               rem_d   = eff_amt;
               error_d = 1'b0;
               state_d = StRun;
            end
         end
         StRun: begin
            acc_d = shifted;
            rem_d = rem_q - step;
            if (rem_q == step) begin
               state_d  = StIdle;
               done_d   = 1'b1;
               result_d = op_ok ? shifted : 8'h00;
               error_d  = ~op_ok;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         acc_q    <= 8'h00;
         rem_q    <= 4'd0;
         op_q     <= 4'd0;
         result_q <= 8'h00;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         rem_q    <= rem_d;
         op_q     <= op_d;
         result_q <= result_d;
         done_q   <= done_d;
         error_q  <= error_d;
      end
   end

   assign bus.busy   = (state_q == StRun);
   assign bus.done   = done_q;
   assign bus.result = result_q;
   assign bus.error  = error_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: one instance with MaxStep=7 and one with MaxStep=1.
module tb_shift_sequencer;

   logic clk;
   logic rst_n;
   int   n_assert;
   int   n_fail;

   shift_sequencer_if if7 ();
   shift_sequencer_if if1 ();

   shift_sequencer #(.MaxStep(7)) u_dut7 (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (if7.slave)
   );

   shift_sequencer #(.MaxStep(1)) u_dut1 (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (if1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit one, input logic st, input logic [3:0] sel,
                        input logic [7:0] d1, input logic [7:0] d2);
      if (one) begin
         if1.start = st; if1.select = sel; if1.data1 = d1; if1.data2 = d2;
      end else begin
         if7.start = st; if7.select = sel; if7.data1 = d1; if7.data2 = d2;
      end
   endtask

   function automatic logic [7:0] busy_of(input bit one);
      return one ? {7'd0, if1.busy} : {7'd0, if7.busy};
   endfunction

   function automatic logic [7:0] done_of(input bit one);
      return one ? {7'd0, if1.done} : {7'd0, if7.done};
   endfunction

   function automatic logic [7:0] err_of(input bit one);
      return one ? {7'd0, if1.error} : {7'd0, if7.error};
   endfunction

   function automatic logic [7:0] res_of(input bit one);
      return one ? if1.result : if7.result;
   endfunction

   // Issue one request at a negedge and follow it through n busy cycles to the done pulse.
   task automatic run_req(input string tag, input bit one, input logic [3:0] sel,
                          input logic [7:0] d1, input logic [7:0] d2, input int n,
                          input logic [7:0] exp_res, input logic exp_err);
      drive(one, 1'b1, sel, d1, d2);
      @(negedge clk);
      drive(one, 1'b0, sel, d1, d2);
      for (int i = 0; i < n; i++) begin
         chk({tag, " busy"}, busy_of(one), 8'd1);
         chk({tag, " no done in run"}, done_of(one), 8'd0);
         chk({tag, " error clear in run"}, err_of(one), 8'd0);
         @(negedge clk);
      end
      chk({tag, " idle at done"}, busy_of(one), 8'd0);
      chk({tag, " done"}, done_of(one), 8'd1);
      chk({tag, " result"}, res_of(one), exp_res);
      chk({tag, " error"}, err_of(one), {7'd0, exp_err});
      @(negedge clk);
      chk({tag, " done one cycle"}, done_of(one), 8'd0);
      chk({tag, " result held"}, res_of(one), exp_res);
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      rst_n    = 1'b1;
      drive(1'b0, 1'b0, 4'h0, 8'h00, 8'h00);
      drive(1'b1, 1'b0, 4'h0, 8'h00, 8'h00);
      #1 rst_n = 1'b0;
      #1;
      chk("reset busy7", busy_of(1'b0), 8'd0);
      chk("reset done7", done_of(1'b0), 8'd0);
      chk("reset result7", res_of(1'b0), 8'h00);
      chk("reset error7", err_of(1'b0), 8'd0);
      chk("reset busy1", busy_of(1'b1), 8'd0);
      chk("reset result1", res_of(1'b1), 8'h00);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_req("lsl81by3", 1'b0, 4'b0101, 8'h81, 8'd3, 1, 8'h08, 1'b0);
      run_req("lsrF0by200", 1'b0, 4'b0100, 8'hF0, 8'd200, 2, 8'h00, 1'b0);
      run_req("ror81by9", 1'b1, 4'b0110, 8'h81, 8'd9, 1, 8'hC0, 1'b0);
      run_req("asr80by3", 1'b1, 4'b0111, 8'h80, 8'd3, 3, 8'hF0, 1'b0);
      run_req("unsupported", 1'b0, 4'b0000, 8'h5A, 8'd2, 1, 8'h00, 1'b1);
      chk("error held while idle", err_of(1'b0), 8'd1);
      run_req("lsl01by1 clears error", 1'b0, 4'b0101, 8'h01, 8'd1, 1, 8'h02, 1'b0);

      // Start held through RUN with different data, then accepted in the done cycle.
      drive(1'b1, 1'b1, 4'b0110, 8'h12, 8'd4);
      @(negedge clk);
      drive(1'b1, 1'b1, 4'b0110, 8'hFF, 8'd4);
      for (int i = 0; i < 4; i++) begin
         chk("held start busy", busy_of(1'b1), 8'd1);
         @(negedge clk);
      end
      chk("held start done", done_of(1'b1), 8'd1);
      chk("held start latched result", res_of(1'b1), 8'h21);
      @(negedge clk);
      drive(1'b1, 1'b0, 4'b0110, 8'hFF, 8'd4);
      chk("start in done cycle accepted", busy_of(1'b1), 8'd1);
      chk("no intermediate result", res_of(1'b1), 8'h21);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("second req busy", busy_of(1'b1), 8'd1);
      end
      @(negedge clk);
      chk("second req done", done_of(1'b1), 8'd1);
      chk("second req result", res_of(1'b1), 8'hFF);
      @(negedge clk);

      // Abort a long request with an asynchronous reset mid-flight.
      drive(1'b1, 1'b1, 4'b0100, 8'hFF, 8'd8);
      @(negedge clk);
      drive(1'b1, 1'b0, 4'b0100, 8'hFF, 8'd8);
      repeat (3) @(negedge clk);
      chk("abort busy before reset", busy_of(1'b1), 8'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort busy", busy_of(1'b1), 8'd0);
      chk("abort result", res_of(1'b1), 8'h00);
      chk("abort done", done_of(1'b1), 8'd0);
      chk("abort result7", res_of(1'b0), 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("no done after abort", done_of(1'b1), 8'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
